// File: rtl/ram_arbiter_if.sv
// Bundle of both requester handshakes and the RAM port shared by ram_arbiter.
// slave: arbiter side; master: the requesters plus the RAM instance.
interface ram_arbiter_if #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 12
) ();
  logic          a_req;
  logic          a_rw;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ack;
  logic [DW-1:0] a_rdata;

  logic          b_req;
  logic          b_rw;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ack;
  logic [DW-1:0] b_rdata;

  logic          mem_cs;
  logic          mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  a_req, a_rw, a_addr, a_wdata,
    input  b_req, b_rw, b_addr, b_wdata,
    input  mem_rdata,
    output a_ack, a_rdata, b_ack, b_rdata,
    output mem_cs, mem_rw, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output a_req, a_rw, a_addr, a_wdata,
    output b_req, b_rw, b_addr, b_wdata,
    output mem_rdata,
    input  a_ack, a_rdata, b_ack, b_rdata,
    input  mem_cs, mem_rw, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two
// four-phase req/ack requesters (A = CPU, B = loader). All outputs registered.
module ram_arbiter #(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 12
) (
  input logic           clk,
  input logic           rstn,
  ram_arbiter_if.slave  bus
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          cmd_rw_q, cmd_rw_d;
  logic          mem_cs_q, mem_cs_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          busy_q, busy_d;

  logic grant_any;
  logic grant_b;
  logic owner_req;

  // On a tie the port that was not served last wins (last_q: 0 = A, 1 = B).
  assign grant_any = bus.a_req | bus.b_req;
  assign grant_b   = bus.b_req & (~bus.a_req | ~last_q);
  assign owner_req = owner_q ? bus.b_req : bus.a_req;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cmd_rw_d    = cmd_rw_q;
    mem_cs_d    = 1'b0;
    mem_rw_d    = 1'b1;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    a_ack_d     = a_ack_q;
    b_ack_d     = b_ack_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;

    case (state_q)
      StIdle: begin
        if (grant_any) begin
          owner_d     = grant_b;
          cmd_rw_d    = grant_b ? bus.b_rw : bus.a_rw;
          mem_cs_d    = 1'b1;
          mem_rw_d    = grant_b ? bus.b_rw : bus.a_rw;
          mem_addr_d  = grant_b ? bus.b_addr : bus.a_addr;
          mem_wdata_d = grant_b ? bus.b_wdata : bus.a_wdata;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        // RAM output is registered, so read data is valid during this state.
        if (cmd_rw_q) begin
          if (owner_q) b_rdata_d = bus.mem_rdata;
          else         a_rdata_d = bus.mem_rdata;
        end
        if (owner_q) b_ack_d = 1'b1;
        else         a_ack_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (!owner_req) begin
          a_ack_d = 1'b0;
          b_ack_d = 1'b0;
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cmd_rw_q    <= 1'b1;
      mem_cs_q    <= 1'b0;
      mem_rw_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cmd_rw_q    <= cmd_rw_d;
      mem_cs_q    <= mem_cs_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_ack_q     <= a_ack_d;
      b_ack_q     <= b_ack_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM plus a reference memory image and
// grant-order expectations derived from the round-robin rules.
module tb_ram_arbiter;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 12;
  localparam int unsigned Depth = 2 ** AW;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DW-1:0] ram [Depth];
  logic [DW-1:0] ram_dout = '0;
  bit            ram_ready = 1'b0;
  int            mem_accesses = 0;
  logic [DW-1:0] ref_mem [Depth];
  bit            model_last = 1'b1;

  ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = ram_dout;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 'h5A5);
  endfunction

  // Single-port RAM: registered read, write on cs with rw = 0; no reset.
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < Depth; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (bus.mem_cs) begin
      mem_accesses <= mem_accesses + 1;
      if (bus.mem_rw) ram_dout <= ram[bus.mem_addr];
      else            ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic set_req(input bit p, input bit r, input bit rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
    if (!p) begin
      bus.a_req = r; bus.a_rw = rw; bus.a_addr = addr; bus.a_wdata = wd;
    end else begin
      bus.b_req = r; bus.b_rw = rw; bus.b_addr = addr; bus.b_wdata = wd;
    end
  endtask

  function automatic bit ack_of(input bit p);
    return p ? bus.b_ack : bus.a_ack;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input bit p);
    return p ? bus.b_rdata : bus.a_rdata;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 20 && (bus.a_ack || bus.b_ack || bus.busy); i++) @(negedge clk);
  endtask

  // Full four-phase access; lat = sampling cycles until ack, -1 on timeout.
  task automatic access(input bit p, input bit rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat);
    set_req(p, 1'b1, rw, addr, wd);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack_of(p)) begin
        lat = i;
        break;
      end
    end
    rd = rdata_of(p);
    set_req(p, 1'b0, rw, addr, wd);
    for (int i = 0; i < 20 && ack_of(p); i++) @(negedge clk);
    if (lat > 0) begin
      if (!rw) ref_mem[addr] = wd;
      model_last = p;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (bus.mem_cs !== 1'b0 || bus.mem_rw !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_mem_ctl: cs=%b rw=%b, required cs=0 rw=1", bus.mem_cs, bus.mem_rw);
      end
    end
    n_checks++;
    if ({bus.a_ack, bus.b_ack, bus.busy, bus.owner} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: a_ack=%b b_ack=%b busy=%b owner=%b, required all 0",
               bus.a_ack, bus.b_ack, bus.busy, bus.owner);
    end
    n_checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.a_rdata !== '0 ||
        bus.b_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h a_rdata=%h b_rdata=%h, required all 0",
               bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata);
    end
    rstn = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_wr_rd();
    int base;
    int lat;
    logic [DW-1:0] rd;
    base = mem_accesses;
    set_req(1'b0, 1'b1, 1'b0, 9'h005, 12'hABC);
    @(negedge clk);
    n_checks++;
    if (bus.mem_cs !== 1'b1 || bus.mem_rw !== 1'b0 || bus.mem_addr !== 9'h005 ||
        bus.mem_wdata !== 12'hABC || bus.busy !== 1'b1 || bus.a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_issue: cs=%b rw=%b addr=%h wdata=%h busy=%b ack=%b, required 1 0 005 abc 1 0",
               bus.mem_cs, bus.mem_rw, bus.mem_addr, bus.mem_wdata, bus.busy, bus.a_ack);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_cs !== 1'b0 || bus.mem_rw !== 1'b1 || bus.a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_capture: cs=%b rw=%b ack=%b, required 0 1 0",
               bus.mem_cs, bus.mem_rw, bus.a_ack);
    end
    @(negedge clk);
    n_checks++;
    if (bus.a_ack !== 1'b1 || bus.owner !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack: ack=%b owner=%b, required ack=1 owner=0", bus.a_ack, bus.owner);
    end
    n_checks++;
    if (mem_accesses - base !== 1) begin
      n_fail++;
      $display("FAIL wr_cs_cycles: %0d cs cycles, required 1", mem_accesses - base);
    end
    set_req(1'b0, 1'b0, 1'b0, 9'h005, 12'hABC);
    ref_mem[5] = 12'hABC;
    model_last = 1'b0;
    wait_idle();
    n_checks++;
    if (bus.a_ack !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_release: ack=%b busy=%b, required 0 0", bus.a_ack, bus.busy);
    end
    access(1'b0, 1'b1, 9'h005, '0, rd, lat);
    n_checks++;
    if (lat !== 3 || rd !== 12'hABC) begin
      n_fail++;
      $display("FAIL rd_back: lat=%0d rdata=%h, required lat=3 rdata=abc", lat, rd);
    end
  endtask

  task automatic test_simultaneous();
    bit got_a = 0, got_b = 0, a_first = 0, overlap = 0;
    logic owner_a = 1'bx, owner_b = 1'bx;
    logic [DW-1:0] rd_a = 'x, rd_b = 'x;
    test_reset();
    set_req(1'b0, 1'b1, 1'b1, 9'h010, '0);
    set_req(1'b1, 1'b1, 1'b1, 9'h011, '0);
    for (int i = 0; i < 40 && !(got_a && got_b); i++) begin
      @(negedge clk);
      if (bus.a_ack && bus.b_ack) overlap = 1'b1;
      if (bus.a_ack && bus.a_req) begin
        got_a = 1'b1; a_first = !got_b; owner_a = bus.owner; rd_a = bus.a_rdata;
        bus.a_req = 1'b0;
      end
      if (bus.b_ack && bus.b_req) begin
        got_b = 1'b1; owner_b = bus.owner; rd_b = bus.b_rdata;
        bus.b_req = 1'b0;
      end
    end
    wait_idle();
    model_last = 1'b1;
    n_checks++;
    if (!(got_a && got_b) || !a_first) begin
      n_fail++;
      $display("FAIL tie_order: got_a=%b got_b=%b a_first=%b, required 1 1 1",
               got_a, got_b, a_first);
    end
    n_checks++;
    if (owner_a !== 1'b0 || owner_b !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_owner: owner_a=%b owner_b=%b, required 0 1", owner_a, owner_b);
    end
    n_checks++;
    if (rd_a !== ref_mem[9'h010] || rd_b !== ref_mem[9'h011]) begin
      n_fail++;
      $display("FAIL tie_rdata: a=%h b=%h, required a=%h b=%h",
               rd_a, rd_b, ref_mem[9'h010], ref_mem[9'h011]);
    end
    n_checks++;
    if (overlap) begin
      n_fail++;
      $display("FAIL tie_exclusive: a_ack and b_ack high together, required never");
    end
  endtask

  // Both ports issue n random accesses each, re-requesting after a random gap.
  task automatic test_traffic(input int n, input int max_gap, input bit check_alt);
    bit            pend [2];
    bit            dropw [2];
    int            gap [2];
    int            left [2];
    int            waits [2];
    bit            rw [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wd [2];
    bit            prev;
    int            completed = 0;
    prev = model_last;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; dropw[p] = 0; gap[p] = 0; left[p] = n; waits[p] = 0;
    end
    for (int cyc = 0; cyc < 3000 && (completed < 2 * n || dropw[0] || dropw[1]); cyc++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        bit q;
        q = bit'(p);
        if (pend[p] && ack_of(q)) begin
          n_checks++;
          if (bus.owner !== q || ack_of(!q) !== 1'b0) begin
            n_fail++;
            $display("FAIL traffic_owner: owner=%b other_ack=%b, required owner=%b other_ack=0",
                     bus.owner, ack_of(!q), q);
          end
          if (rw[p]) begin
            n_checks++;
            if (rdata_of(q) !== ref_mem[addr[p]]) begin
              n_fail++;
              $display("FAIL traffic_rdata: port=%0d addr=%h rdata=%h, required %h",
                       p, addr[p], rdata_of(q), ref_mem[addr[p]]);
            end
          end else begin
            ref_mem[addr[p]] = wd[p];
          end
          n_checks++;
          if (waits[p] > 1) begin
            n_fail++;
            $display("FAIL traffic_fair: port=%0d waited %0d foreign accesses, required <=1",
                     p, waits[p]);
          end
          if (check_alt) begin
            n_checks++;
            if (q == prev) begin
              n_fail++;
              $display("FAIL traffic_alternate: granted port %0d, required port %0d", q, !prev);
            end
          end
          prev = q;
          if (pend[1-p]) waits[1-p]++;
          waits[p] = 0; pend[p] = 0; dropw[p] = 1; completed++;
          set_req(q, 1'b0, rw[p], addr[p], wd[p]);
        end else if (dropw[p]) begin
          if (!ack_of(q)) begin
            dropw[p] = 0;
            gap[p] = $urandom_range(0, max_gap);
            model_last = q;
          end
        end else if (!pend[p] && left[p] > 0) begin
          if (gap[p] == 0) begin
            rw[p]   = 1'($urandom_range(0, 1));
            addr[p] = ($urandom_range(0, 3) == 0) ? AW'(Depth - 1) : AW'($urandom_range(0, 7));
            wd[p]   = DW'($urandom);
            pend[p] = 1; left[p]--;
            set_req(q, 1'b1, rw[p], addr[p], wd[p]);
          end else begin
            gap[p]--;
          end
        end
      end
    end
    n_checks++;
    if (completed != 2 * n) begin
      n_fail++;
      $display("FAIL traffic_timeout: %0d accesses completed, required %0d", completed, 2 * n);
    end
    set_req(1'b0, 1'b0, 1'b1, '0, '0);
    set_req(1'b1, 1'b0, 1'b1, '0, '0);
    wait_idle();
  endtask

  task automatic test_four_phase();
    int base;
    int lat = -1;
    bit hold_ok = 1;
    bit got_a = 0;
    logic [DW-1:0] wd;
    wd = DW'($urandom);
    base = mem_accesses;
    set_req(1'b1, 1'b1, 1'b0, 9'h030, wd);
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.b_ack) lat = i;
    end
    ref_mem[9'h030] = wd;
    set_req(1'b0, 1'b1, 1'b1, 9'h020, '0);
    repeat (5) begin
      @(negedge clk);
      if (!(bus.b_ack && bus.busy && !bus.a_ack && !bus.mem_cs)) hold_ok = 0;
    end
    n_checks++;
    if (lat !== 3 || !hold_ok) begin
      n_fail++;
      $display("FAIL hold_ack: lat=%0d hold_ok=%b, required lat=3 hold_ok=1", lat, hold_ok);
    end
    n_checks++;
    if (mem_accesses - base !== 1) begin
      n_fail++;
      $display("FAIL hold_single_access: %0d RAM accesses, required 1", mem_accesses - base);
    end
    bus.b_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.b_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: b_ack=%b, required 0", bus.b_ack);
    end
    for (int i = 0; i < 20 && !got_a; i++) begin
      @(negedge clk);
      got_a = bus.a_ack;
    end
    n_checks++;
    if (!got_a || bus.owner !== 1'b0 || bus.a_rdata !== ref_mem[9'h020]) begin
      n_fail++;
      $display("FAIL hold_then_a: ack=%b owner=%b rdata=%h, required 1 0 %h",
               got_a, bus.owner, bus.a_rdata, ref_mem[9'h020]);
    end
    bus.a_req = 1'b0;
    wait_idle();
    model_last = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int lat;
    logic [DW-1:0] rd;
    set_req(1'b0, 1'b1, 1'b0, 9'h00F, 12'h123);
    @(posedge clk);
    #2;
    n_checks++;
    if (bus.mem_cs !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_issue: cs=%b before reset, required 1", bus.mem_cs);
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_cs !== 1'b0 || bus.busy !== 1'b0 || bus.a_ack !== 1'b0 ||
        bus.mem_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: cs=%b rw=%b busy=%b ack=%b, required 0 1 0 0",
               bus.mem_cs, bus.mem_rw, bus.busy, bus.a_ack);
    end
    set_req(1'b0, 1'b0, 1'b0, 9'h00F, 12'h123);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.a_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_ack: a_ack=%b, required 0", bus.a_ack);
    end
    access(1'b0, 1'b1, 9'h00F, '0, rd, lat);
    n_checks++;
    if (lat !== 3 || rd !== init_val(15)) begin
      n_fail++;
      $display("FAIL midrst_readback: lat=%0d rdata=%h, required lat=3 rdata=%h",
               lat, rd, init_val(15));
    end
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) ref_mem[i] = init_val(i);
    set_req(1'b0, 1'b0, 1'b1, '0, '0);
    set_req(1'b1, 1'b0, 1'b1, '0, '0);
    test_reset();
    test_single_wr_rd();
    test_simultaneous();
    test_traffic(4, 0, 1'b1);
    test_four_phase();
    test_reset_mid_write();
    test_traffic(20, 3, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares one single-port synchronous RAM (`genram`: one `cs`, one `rw` with 1 = read and 0 = write, registered `data_out` with 1-cycle read latency) between two requesters. Port A is the Simplez CPU; port B is the serial loader/monitor. The block sequences every access through a small FSM and returns read data on a four-phase req/ack handshake. It sits between both masters and the RAM instance.

## Interface
Parameters:
- `AW`, 9, address width; must match the RAM.
- `DW`, 12, data width; must match the RAM.

Ports:
- `clk`  in  1  single global clock; all state changes on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `a_req`  in  1  port A request level; holds until `a_ack` is seen.
- `a_rw`  in  1  port A direction, 1 = read, 0 = write; stable while `a_req` = 1.
- `a_addr`  in  AW  port A address; stable while `a_req` = 1.
- `a_wdata`  in  DW  port A write data; stable while `a_req` = 1.
- `a_ack`  out  1  port A acknowledge; held high until `a_req` falls.
- `a_rdata`  out  DW  port A read data; valid whenever `a_ack` = 1 after a read.
- `b_req`, `b_rw`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: identical to port A, for port B.
- `mem_cs`  out  1  RAM chip select.
- `mem_rw`  out  1  RAM direction, 1 = read.
- `mem_addr`  out  AW  RAM address.
- `mem_wdata`  out  DW  RAM write data.
- `mem_rdata`  in  DW  RAM registered read data.
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  1  port of the current or most recent grant, 0 = A, 1 = B.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE. All outputs are registered.
- **IDLE**
  - If no `x_req` is high, stay in IDLE.
  - If exactly one `x_req` is high, grant that port.
  - If both are high, grant the port not served last (round-robin on `last`).
  - On a grant: latch the winner's rw/addr/wdata, set `owner`, go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Drive `mem_cs`=1, `mem_rw`, `mem_addr` and `mem_wdata` from the latched command.
  - The RAM executes the access on the edge that leaves ISSUE.
  - Go to CAPTURE.
- **CAPTURE** (1 cycle)
  - `mem_cs`=0 and `mem_rw`=1.
  - For a read, register `mem_rdata` into the winner's `x_rdata` on the exiting edge.
  - For a write, `x_rdata` is unchanged.
  - Assert the winner's `x_ack` and go to DONE.
- **DONE**
  - Hold `x_ack`=1 while the winner's `x_req`=1.
  - When the winner's `x_req`=0, clear `x_ack`, update `last` to the winner and go to IDLE.
  - The other port's req is ignored until IDLE.
- Outside ISSUE: `mem_cs`=0 and `mem_rw`=1 (read-safe). `mem_addr`/`mem_wdata` hold their last values.
- Requests are never pre-empted. A losing port waits with its req held and is guaranteed service after at most one access by the other port.
- Changing rw/addr/wdata while req is high is illegal; the latched copy is used.

## Timing
- Reset values: `mem_cs`=0, `mem_rw`=1, `mem_addr`=0, `mem_wdata`=0, `a_ack`=`b_ack`=0, `a_rdata`=`b_rdata`=0, `busy`=0, `owner`=0, `last`=B (so A wins the first tie), state IDLE.
- Latency: req sampled high at edge E0 in IDLE:
  - `mem_cs`=1 during E0–E1.
  - RAM acts at E1.
  - `x_ack`=1 and `x_rdata` valid from E2.
- Minimum access time is 3 cycles from req to ack, plus 1 cycle in DONE after req falls.
- Back-to-back grants: after DONE→IDLE at edge En, a pending req is granted at En+1. IDLE lasts at least 1 cycle between accesses.
- Mid-operation reset (`rstn` low):
  - All outputs go to reset values immediately (asynchronous); `mem_cs` drops in the same cycle.
  - A write in ISSUE whose executing edge has not occurred is abandoned.
  - No ack is produced for any in-flight access.
- Address wrap is not applicable: the full `2**AW` range is passed through unmodified.

## Test plan
- **Reset values:** hold `rstn`=0 for 3 cycles → all outputs at reset values; `mem_rw`=1 and `mem_cs`=0 throughout.
- **Single write then read on A:**
  - A writes addr 0x005, data 0xABC → `mem_cs` high exactly 1 cycle with `mem_rw`=0; `a_ack` rises 2 cycles after the grant edge.
  - Then A reads 0x005 → `a_rdata`=0xABC while `a_ack`=1.
- **Simultaneous requests from reset:**
  - A reads 0x010 and B reads 0x011 in the same cycle → A is served first (`owner`=0), then B (`owner`=1).
  - `b_ack` never high while `a_ack` is high.
- **Round-robin fairness:**
  - Both ports keep re-requesting for 8 accesses → grants alternate A,B,A,B…
  - No port waits for more than one foreign access.
- **Four-phase hold:** B holds `b_req` for 5 cycles after `b_ack` → `b_ack` stays high for 5 cycles; no second RAM access occurs; `busy`=1 throughout.
- **Reset mid-write:** assert `rstn`=0 during ISSUE, before the executing edge, of a write of 0x123 to 0x00F → the old content of 0x00F reads back after reset; `mem_cs` falls asynchronously.
